// File: rtl/mem_controller.sv
// Round-robin arbiter between NUM_CONSUMERS LSU ports and a single memory read/write port.
// One transaction in flight; mem valid rises one edge after grant, consumer ready one edge after mem ready.
module mem_controller #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int PW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } state_t;

  state_t                           state, state_nxt;
  logic [PW-1:0]                    grant_idx, grant_nxt;
  logic [PW-1:0]                    rr_ptr, rr_nxt;
  logic                             mrv_nxt, mwv_nxt;
  logic [ADDR_BITS-1:0]             mra_nxt, mwa_nxt;
  logic [DATA_BITS-1:0]             mwd_nxt;
  logic [NUM_CONSUMERS-1:0]         crr_nxt, cwr_nxt;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] crd_nxt;

  logic                             found;
  logic                             sel_read;
  logic [PW-1:0]                    sel;
  logic [PW-1:0]                    scan_idx;
  int                               scan_sum;

  // First requester at or after rr_ptr wins; read beats write on the same port.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    sel_read = 1'b0;
    scan_sum = 0;
    scan_idx = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      scan_sum = int'(rr_ptr) + k;
      if (scan_sum >= NUM_CONSUMERS) scan_sum = scan_sum - NUM_CONSUMERS;
      scan_idx = scan_sum[PW-1:0];
      if (!found && (consumer_read_valid[scan_idx] || consumer_write_valid[scan_idx])) begin
        found    = 1'b1;
        sel      = scan_idx;
        sel_read = consumer_read_valid[scan_idx];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_idx;
    rr_nxt    = rr_ptr;
    mrv_nxt   = mem_read_valid;
    mra_nxt   = mem_read_address;
    mwv_nxt   = mem_write_valid;
    mwa_nxt   = mem_write_address;
    mwd_nxt   = mem_write_data;
    crr_nxt   = consumer_read_ready;
    cwr_nxt   = consumer_write_ready;
    crd_nxt   = consumer_read_data;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = sel;
          rr_nxt    = (sel == PW'(NUM_CONSUMERS - 1)) ? '0 : sel + 1'b1;
          if (sel_read) begin
            mrv_nxt   = 1'b1;
            mra_nxt   = consumer_read_address[sel*ADDR_BITS +: ADDR_BITS];
            state_nxt = READ_WAITING;
          end else begin
            mwv_nxt   = 1'b1;
            mwa_nxt   = consumer_write_address[sel*ADDR_BITS +: ADDR_BITS];
            mwd_nxt   = consumer_write_data[sel*DATA_BITS +: DATA_BITS];
            state_nxt = WRITE_WAITING;
          end
        end
      end
      READ_WAITING: begin
        if (mem_read_ready) begin
          mrv_nxt                                    = 1'b0;
          crd_nxt[grant_idx*DATA_BITS +: DATA_BITS] = mem_read_data;
          crr_nxt[grant_idx]                         = 1'b1;
          state_nxt                                  = READ_RELAYING;
        end
      end
      WRITE_WAITING: begin
        if (mem_write_ready) begin
          mwv_nxt            = 1'b0;
          cwr_nxt[grant_idx] = 1'b1;
          state_nxt          = WRITE_RELAYING;
        end
      end
      // Ready is held until the granted consumer withdraws its request.
      READ_RELAYING: begin
        if (!consumer_read_valid[grant_idx]) begin
          crr_nxt[grant_idx] = 1'b0;
          state_nxt          = IDLE;
        end
      end
      WRITE_RELAYING: begin
        if (!consumer_write_valid[grant_idx]) begin
          cwr_nxt[grant_idx] = 1'b0;
          state_nxt          = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      grant_idx            <= '0;
      rr_ptr               <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
    end else begin
      state                <= state_nxt;
      grant_idx            <= grant_nxt;
      rr_ptr               <= rr_nxt;
      mem_read_valid       <= mrv_nxt;
      mem_read_address     <= mra_nxt;
      mem_write_valid      <= mwv_nxt;
      mem_write_address    <= mwa_nxt;
      mem_write_data       <= mwd_nxt;
      consumer_read_ready  <= crr_nxt;
      consumer_write_ready <= cwr_nxt;
      consumer_read_data   <= crd_nxt;
    end
  end

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller: directed requests push expected memory/consumer events,
// a negedge monitor pops and compares them as the controller presents them.
module tb_mem_controller;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int K_MRD = 0, K_MWR = 1, K_CRD = 2, K_CWR = 3;

  typedef struct {
    int         kind;
    int         idx;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    rv, wv;
  logic [N*AW-1:0] ra, wa;
  logic [N*DW-1:0] wd;
  logic [N-1:0]    consumer_read_ready, consumer_write_ready;
  logic [N*DW-1:0] consumer_read_data;
  logic            mem_read_valid, mem_write_valid;
  logic [AW-1:0]   mem_read_address, mem_write_address;
  logic [DW-1:0]   mem_write_data;
  logic            mem_read_ready, mem_write_ready;
  logic [DW-1:0]   mem_read_data;

  mem_controller #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (rv),
    .consumer_read_address  (ra),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (wv),
    .consumer_write_address (wa),
    .consumer_write_data    (wd),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
  );

  int         checks = 0;
  int         fails  = 0;
  ev_t        exp_q[$];
  logic [7:0] mem [256];
  int         mem_lat = 3;
  bit         stray_wr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int idx, input logic [7:0] addr, input logic [7:0] data);
    exp_q.push_back('{kind, idx, addr, data});
  endtask

  task automatic got(input int kind, input int idx, input logic [7:0] addr, input logic [7:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL unexpected_event: kind=%0d idx=%0d addr=0x%0h data=0x%0h, expected none", kind, idx, addr, data);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_idx", idx, e.idx);
      check("ev_addr", {24'd0, addr}, {24'd0, e.addr});
      check("ev_data", {24'd0, data}, {24'd0, e.data});
    end
  endtask

  // Memory model: responds mem_lat cycles after a request appears; may inject a stray write ready.
  initial begin
    int cnt;
    cnt = 0;
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data   = '0;
    forever begin
      @(negedge clk);
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
      if (mem_read_valid || mem_write_valid) begin
        cnt++;
        if (stray_wr && mem_read_valid && cnt == 2) mem_write_ready = 1'b1;
        if (cnt == mem_lat) begin
          if (mem_read_valid) begin
            mem_read_ready = 1'b1;
            mem_read_data  = mem[mem_read_address];
          end else begin
            mem_write_ready = 1'b1;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every rising request/completion.
  initial begin
    logic         p_mrv, p_mwv;
    logic [N-1:0] p_crr, p_cwr;
    p_mrv = 1'b0; p_mwv = 1'b0; p_crr = '0; p_cwr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (mem_read_valid && !p_mrv) got(K_MRD, 0, mem_read_address, 8'h00);
        if (mem_write_valid && !p_mwv) got(K_MWR, 0, mem_write_address, mem_write_data);
        for (int i = 0; i < N; i++) begin
          if (consumer_read_ready[i] && !p_crr[i]) got(K_CRD, i, 8'h00, consumer_read_data[i*DW +: DW]);
          if (consumer_write_ready[i] && !p_cwr[i]) got(K_CWR, i, 8'h00, 8'h00);
        end
        check("onehot_ready", {31'd0, $onehot0({consumer_read_ready, consumer_write_ready})}, 32'd1);
        check("single_mem_valid", {31'd0, mem_read_valid & mem_write_valid}, 32'd0);
        p_mrv = mem_read_valid; p_mwv = mem_write_valid;
        p_crr = consumer_read_ready; p_cwr = consumer_write_ready;
      end else begin
        p_mrv = 1'b0; p_mwv = 1'b0; p_crr = '0; p_cwr = '0;
      end
    end
  end

  // Waits for a completion, checks it stays held for `hold` cycles, then withdraws the request.
  task automatic serve(input int hold, input bit again, output int who, output bit rd);
    logic [7:0] expv;
    who = -1;
    rd  = 1'b0;
    for (int c = 0; c < 60 && who < 0; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (consumer_read_ready[i])  begin who = i; rd = 1'b1; end
        if (consumer_write_ready[i]) begin who = i; rd = 1'b0; end
      end
    end
    if (who < 0) begin
      check("serve_timeout", 32'd1, 32'd0);
    end else begin
      expv = rd ? 8'(1 << (who + 4)) : 8'(1 << who);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("ready_held", {24'd0, consumer_read_ready, consumer_write_ready}, {24'd0, expv});
      end
      if (rd) rv[who] = 1'b0;
      else    wv[who] = 1'b0;
      @(negedge clk);
      check("ready_dropped", {24'd0, consumer_read_ready, consumer_write_ready}, 32'd0);
      if (again) rv[who] = 1'b1;
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int who;
    bit rd;
    bit seen;
    rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
    mem[8'h1A] = 8'h5C;
    mem[8'h10] = 8'h11;
    mem[8'h30] = 8'h33;
    mem[8'h50] = 8'h5A;
    mem[8'h60] = 8'hEE;
    mem[8'h70] = 8'hC7;
    mem[8'h71] = 8'hD3;
    for (int i = 0; i < N; i++) mem[8'(64 + i)] = 8'(160 + i);

    repeat (2) @(negedge clk);
    check("rst_mem_read_valid", {31'd0, mem_read_valid}, 32'd0);
    check("rst_mem_write_valid", {31'd0, mem_write_valid}, 32'd0);
    check("rst_mem_addrs", {16'd0, mem_read_address, mem_write_address}, 32'd0);
    check("rst_mem_write_data", {24'd0, mem_write_data}, 32'd0);
    check("rst_consumer_ready", {24'd0, consumer_read_ready, consumer_write_ready}, 32'd0);
    check("rst_consumer_read_data", consumer_read_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single read by consumer 2, memory latency 3
    mem_lat = 3;
    push(K_MRD, 0, 8'h1A, 8'h00);
    push(K_CRD, 2, 8'h00, 8'h5C);
    @(negedge clk);
    ra[2*AW +: AW] = 8'h1A;
    rv[2] = 1'b1;
    @(negedge clk);
    check("t1_mem_valid_latency", {31'd0, mem_read_valid}, 32'd1);
    check("t1_mem_addr", {24'd0, mem_read_address}, 32'h1A);
    serve(3, 1'b0, who, rd);
    check("t1_who", who, 2);
    check("t1_data_held", {24'd0, consumer_read_data[2*DW +: DW]}, 32'h5C);

    // Single write by consumer 0
    mem_lat = 2;
    push(K_MWR, 0, 8'h03, 8'h77);
    push(K_CWR, 0, 8'h00, 8'h00);
    wa[0 +: AW] = 8'h03;
    wd[0 +: DW] = 8'h77;
    wv[0] = 1'b1;
    serve(2, 1'b0, who, rd);
    check("t2_who", who, 0);
    check("t2_is_write", {31'd0, rd}, 32'd0);

    // Fairness from reset: all four read continuously
    reset_pulse();
    mem_lat = 1;
    for (int k = 0; k < 5; k++) begin
      push(K_MRD, 0, 8'(64 + k % 4), 8'h00);
      push(K_CRD, k % 4, 8'h00, 8'(160 + k % 4));
    end
    for (int i = 0; i < N; i++) ra[i*AW +: AW] = 8'(64 + i);
    rv = 4'hF;
    for (int k = 0; k < 5; k++) begin
      serve(0, k < 4, who, rd);
      check("t3_order", who, k % 4);
      if (k == 4) rv = '0;
    end

    // Read and write on consumer 1 together, consumer 2 also pending
    mem_lat = 2;
    push(K_MRD, 0, 8'h10, 8'h00);
    push(K_CRD, 1, 8'h00, 8'h11);
    push(K_MRD, 0, 8'h30, 8'h00);
    push(K_CRD, 2, 8'h00, 8'h33);
    push(K_MWR, 0, 8'h20, 8'h99);
    push(K_CWR, 1, 8'h00, 8'h00);
    ra[1*AW +: AW] = 8'h10;
    wa[1*AW +: AW] = 8'h20;
    wd[1*DW +: DW] = 8'h99;
    ra[2*AW +: AW] = 8'h30;
    rv[1] = 1'b1; wv[1] = 1'b1; rv[2] = 1'b1;
    serve(0, 1'b0, who, rd);
    check("t4_first_who", who, 1);
    check("t4_first_is_read", {31'd0, rd}, 32'd1);
    serve(0, 1'b0, who, rd);
    check("t4_second_who", who, 2);
    serve(0, 1'b0, who, rd);
    check("t4_third_who", who, 1);
    check("t4_third_is_write", {31'd0, rd}, 32'd0);

    // Stray mem_write_ready during a read wait
    mem_lat = 4;
    stray_wr = 1'b1;
    push(K_MRD, 0, 8'h50, 8'h00);
    push(K_CRD, 3, 8'h00, 8'h5A);
    ra[3*AW +: AW] = 8'h50;
    rv[3] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      if (mem_write_ready) seen = 1'b1;
    end
    check("t5_stray_pulse_issued", {31'd0, seen}, 32'd1);
    @(negedge clk);
    check("t5_still_waiting", {31'd0, mem_read_valid}, 32'd1);
    check("t5_no_completion", {24'd0, consumer_read_ready, consumer_write_ready}, 32'd0);
    serve(0, 1'b0, who, rd);
    stray_wr = 1'b0;
    check("t5_who", who, 3);

    // Reset asserted in READ_WAITING
    mem_lat = 100;
    push(K_MRD, 0, 8'h60, 8'h00);
    ra[0 +: AW] = 8'h60;
    rv[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_waiting_before_reset", {31'd0, mem_read_valid}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("t6_async_mem_read_valid", {31'd0, mem_read_valid}, 32'd0);
    check("t6_async_ready", {24'd0, consumer_read_ready, consumer_write_ready}, 32'd0);
    check("t6_async_read_data", consumer_read_data, 32'd0);
    rv = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mem_lat = 2;
    push(K_MRD, 0, 8'h70, 8'h00);
    push(K_CRD, 0, 8'h00, 8'hC7);
    push(K_MRD, 0, 8'h71, 8'h00);
    push(K_CRD, 1, 8'h00, 8'hD3);
    ra[0 +: AW] = 8'h70;
    ra[1*AW +: AW] = 8'h71;
    rv[0] = 1'b1; rv[1] = 1'b1;
    serve(0, 1'b0, who, rd);
    check("t6_rr_ptr_zero_first", who, 0);
    serve(0, 1'b0, who, rd);
    check("t6_rr_ptr_zero_second", who, 1);

    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d fails=%0d", checks, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
